// File: rtl/uart_tx_ctrl_if.sv
// Host, baud-generator and serial-line signals of the UART transmit sequencer.
// The slave modport is the sequencer's view; master is the surrounding host/generator.
interface uart_tx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 cfg_req;
    logic [15:0]          cfg_word;
    logic                 cfg_ack;
    logic                 latch;
    logic [15:0]          baud_word;
    logic                 baud_ena;
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 txd;
    logic                 busy;

    modport slave (
        input  cfg_req, cfg_word, baud_ena, tx_valid, tx_data,
        output cfg_ack, latch, baud_word, tx_ready, txd, busy
    );

    modport master (
        output cfg_req, cfg_word, baud_ena, tx_valid, tx_data,
        input  cfg_ack, latch, baud_word, tx_ready, txd, busy
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: owns baud_gen configuration and shifts start/data/stop bits on ena ticks.
// txd changes one cycle after a sampled ena; tx_ready is dropped outside IDLE and whenever cfg_req is pending.
module uart_tx_ctrl #(
    parameter int          DATA_BITS = 8,
    parameter logic [15:0] DEF_BAUD  = 16'd434
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_ctrl_if.slave  bus
);
    localparam int             CW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DATA_BITS - 1);

    typedef enum logic [2:0] {INIT, IDLE, CFG, SYNC, START, DATA, STOP} state_t;

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [CW-1:0]        bit_cnt, cnt_nxt;
    logic                 txd_q, txd_nxt;
    logic                 latch_q, latch_nxt;
    logic                 ack_q, ack_nxt;
    logic [15:0]          word_q, word_nxt;
    logic                 ready_q;
    logic                 busy_q;
    logic                 tx_ready;

    // A pending cfg_req masks ready in the same cycle so a byte is never
    // seen as accepted while IDLE is about to service the configuration.
    assign tx_ready      = ready_q & ~bus.cfg_req;
    assign bus.tx_ready  = tx_ready;
    assign bus.txd       = txd_q;
    assign bus.latch     = latch_q;
    assign bus.cfg_ack   = ack_q;
    assign bus.baud_word = word_q;
    assign bus.busy      = busy_q;

    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        cnt_nxt   = bit_cnt;
        txd_nxt   = txd_q;
        latch_nxt = 1'b0;
        ack_nxt   = 1'b0;
        word_nxt  = word_q;
        case (state)
            INIT: begin
                latch_nxt = 1'b1;
                word_nxt  = DEF_BAUD;
                state_nxt = IDLE;
            end
            IDLE: begin
                txd_nxt = 1'b1;
                if (bus.cfg_req) begin
                    latch_nxt = 1'b1;
                    ack_nxt   = 1'b1;
                    // Zero would make the generator wrap to a 65536-cycle period.
                    word_nxt  = (bus.cfg_word == 16'd0) ? 16'd1 : bus.cfg_word;
                    state_nxt = CFG;
                end else if (bus.tx_valid && tx_ready) begin
                    shift_nxt = bus.tx_data;
                    state_nxt = SYNC;
                end
            end
            CFG: state_nxt = IDLE;
            SYNC: begin
                if (bus.baud_ena) begin
                    txd_nxt   = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bus.baud_ena) begin
                    txd_nxt   = shift[0];
                    shift_nxt = shift >> 1;
                    cnt_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bus.baud_ena) begin
                    if (bit_cnt == LAST) begin
                        txd_nxt   = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        txd_nxt   = shift[0];
                        shift_nxt = shift >> 1;
                        cnt_nxt   = bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bus.baud_ena) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= INIT;
            shift   <= '0;
            bit_cnt <= '0;
            txd_q   <= 1'b1;
            latch_q <= 1'b0;
            ack_q   <= 1'b0;
            word_q  <= DEF_BAUD;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_cnt <= cnt_nxt;
            txd_q   <= txd_nxt;
            latch_q <= latch_nxt;
            ack_q   <= ack_nxt;
            word_q  <= word_nxt;
            ready_q <= (state_nxt == IDLE);
            busy_q  <= (state_nxt != IDLE);
        end
    end
endmodule
